// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op/state encodings and handshake levels for the mul/div sequencer
package muldiv_ctrl_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DIV = 2'b10, DONE = 2'b11} md_state_e;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  function automatic logic op_is_div(md_op_e op);
    return op[1];
  endfunction
  function automatic logic op_is_signed(md_op_e op);
    return ~op[0];
  endfunction
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX request, multiplier and divider wiring around the mul/div sequencer
interface muldiv_ctrl_if #(parameter int DATA_W = 32);
  logic req_valid;
  logic [1:0] req_op;
  logic [DATA_W-1:0] req_src1;
  logic [DATA_W-1:0] req_src2;
  logic annul;
  logic ex_hold;
  logic mul_signed;
  logic [DATA_W-1:0] mul_ina;
  logic [DATA_W-1:0] mul_inb;
  logic [2*DATA_W-1:0] mul_result;
  logic div_start;
  logic div_signed;
  logic [DATA_W-1:0] div_opdata1;
  logic [DATA_W-1:0] div_opdata2;
  logic div_annul;
  logic [2*DATA_W-1:0] div_result;
  logic div_ready;
  logic stallreq;
  logic hilo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic busy;
  modport slave (
    input req_valid, req_op, req_src1, req_src2, annul, ex_hold, mul_result, div_result, div_ready,
    output mul_signed, mul_ina, mul_inb, div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    output stallreq, hilo_we, hi_wdata, lo_wdata, busy
  );
  modport master (
    output req_valid, req_op, req_src1, req_src2, annul, ex_hold, mul_result, div_result, div_ready,
    input mul_signed, mul_ina, mul_inb, div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    input stallreq, hilo_we, hi_wdata, lo_wdata, busy
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: latches one mul/div request, sequences the multiplier or divider,
// stalls EX until the result is captured, then pulses the HI/LO write once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  md_state_e state, state_nx;
  md_op_e op;
  logic [DATA_W-1:0] src1, src2, hi, lo;
  logic [CW-1:0] count;
  logic accept, in_mul, in_div, cap_mul, cap_div;
  assign in_mul = state == MUL;
  assign in_div = state == DIV;
  assign accept = state == IDLE && bus.req_valid && !bus.annul;
  assign cap_mul = in_mul && count == '0 && !bus.annul;
  assign cap_div = in_div && bus.div_ready && !bus.annul;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= MD_MULT;
      src1 <= '0;
      src2 <= '0;
      count <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= md_op_e'(bus.req_op);
        src1 <= bus.req_src1;
        src2 <= bus.req_src2;
        if (!bus.req_op[1]) count <= CW'(MUL_LAT - 1);
      end else if (in_mul && count != '0) count <= count - CW'(1);
      if (cap_mul) {hi, lo} <= bus.mul_result;
      else if (cap_div) {hi, lo} <= bus.div_result;
    end
  end
  always_comb begin
    state_nx = state;
    if (bus.annul) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = bus.req_valid ? (bus.req_op[1] ? DIV : MUL) : IDLE;
        MUL: state_nx = count == '0 ? DONE : MUL;
        DIV: state_nx = bus.div_ready == DIV_RESULT_READY ? DONE : DIV;
        DONE: state_nx = bus.ex_hold ? DONE : IDLE;
      endcase
  end
  // Reset forces IDLE asynchronously; the request term is gated so stallreq drops with it.
  assign bus.stallreq = (accept && !rst) || in_mul || in_div ? STOP : NO_STOP;
  assign bus.busy = state != IDLE;
  assign bus.hilo_we = state == DONE && !bus.ex_hold && !bus.annul;
  assign bus.hi_wdata = hi;
  assign bus.lo_wdata = lo;
  assign bus.mul_signed = in_mul && op_is_signed(op);
  assign bus.mul_ina = in_mul ? src1 : '0;
  assign bus.mul_inb = in_mul ? src2 : '0;
  assign bus.div_start = in_div ? DIV_START : DIV_STOP;
  assign bus.div_signed = in_div && op_is_signed(op);
  assign bus.div_opdata1 = in_div ? src1 : '0;
  assign bus.div_opdata2 = in_div ? src2 : '0;
  assign bus.div_annul = in_div && bus.annul;
endmodule
